// File: rtl/upgrade_pkg.sv
// Shared types and default plate geometry for the upgrade pickup controllers.
package upgrade_pkg;

   typedef enum logic [1:0] {
      DIR_LEFT  = 2'b00,
      DIR_RIGHT = 2'b01,
      DIR_DOWN  = 2'b10,
      DIR_UP    = 2'b11
   } dir_t;

   typedef enum logic [1:0] {
      SPAWNED = 2'd0,
      HELD    = 2'd1,
      RESPAWN = 2'd2
   } upg_state_t;

   localparam int ARMOR_LONG_DEF  = 12;
   localparam int ARMOR_SHORT_DEF = 4;
   localparam int ARMOR_GAP_DEF   = 10;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic [9:0] len;
      logic [9:0] ht;
   } plate_t;

   // Plate sits behind the player; positions wrap mod 1024 and the renderer clips.
   function automatic plate_t rear_plate(input logic [9:0] px, input logic [9:0] py,
                                         input logic [9:0] bs, input dir_t dir,
                                         input logic [9:0] gap, input logic [9:0] lng,
                                         input logic [9:0] shrt);
      plate_t p;
      logic [9:0] off;
      off   = bs + gap;
      p.x   = px;
      p.y   = py;
      p.len = lng;
      p.ht  = shrt;
      case (dir)
         DIR_LEFT: begin
            p.x   = px + off;
            p.len = shrt;
            p.ht  = lng;
         end
         DIR_RIGHT: begin
            p.x   = px - off;
            p.len = shrt;
            p.ht  = lng;
         end
         DIR_DOWN: p.y = py - off;
         default:  p.y = py + off;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/upgrade_hitbox.sv
// Inclusive box-overlap test of a point against a square pickup.
// Span bounds are widened to 11 bits and clamped to the 0..1023 field.
module upgrade_hitbox (
   input  logic [9:0] px,
   input  logic [9:0] py,
   input  logic [9:0] cx,
   input  logic [9:0] cy,
   input  logic [9:0] size,
   output logic       hit
);

   function automatic logic in_span(input logic [9:0] p, input logic [9:0] c,
                                    input logic [9:0] s);
      logic [10:0] lo;
      logic [10:0] hi;
      lo = ({1'b0, c} >= {1'b0, s}) ? ({1'b0, c} - {1'b0, s}) : 11'd0;
      hi = {1'b0, c} + {1'b0, s};
      if (hi > 11'd1023) hi = 11'd1023;
      return ({1'b0, p} >= lo) && ({1'b0, p} <= hi);
   endfunction

   assign hit = in_span(px, cx, size) && in_span(py, cy, size);

endmodule

// File: rtl/upgrade_armor_ctrl.sv
// Armor pickup controller: spawn/hold/respawn lifecycle, pickup arbitration,
// rear plate placement and hit absorption for NUM_PLAYERS tanks.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   SPAWNED | pickup on the field, waiting for a player to overlap it
//   HELD    | owner carries the plate; absorbs hits until broken or expired
//   RESPAWN | pickup gone, counting down to reappearance; overlaps ignored
module upgrade_armor_ctrl
   import upgrade_pkg::*;
#(
   parameter int NUM_PLAYERS    = 2,
   parameter int ARMOR_LONG     = ARMOR_LONG_DEF,
   parameter int ARMOR_SHORT    = ARMOR_SHORT_DEF,
   parameter int ARMOR_GAP      = ARMOR_GAP_DEF,
   parameter int HOLD_FRAMES    = 600,
   parameter int RESPAWN_FRAMES = 300,
   parameter int HITS_MAX       = 3
) (
   input  logic                                frame_clk,
   input  logic                                Reset,
   input  logic [NUM_PLAYERS-1:0][9:0]         PlayerX,
   input  logic [NUM_PLAYERS-1:0][9:0]         PlayerY,
   input  logic [9:0]                          Ball_Size,
   input  logic [NUM_PLAYERS-1:0][1:0]         player_dir,
   input  logic [NUM_PLAYERS-1:0]              player_hit,
   input  logic [9:0]                          UpgradeX,
   input  logic [9:0]                          UpgradeY,
   input  logic [9:0]                          Upgrade_Size,
   output logic                                upgrade_visible,
   output logic [NUM_PLAYERS-1:0]              armor_owner,
   output logic [9:0]                          ArmorX,
   output logic [9:0]                          ArmorY,
   output logic [9:0]                          Armor_Length_Halved,
   output logic [9:0]                          Armor_Height_Halved,
   output logic [$clog2(HITS_MAX+1)-1:0]       hits_left,
   output logic [NUM_PLAYERS-1:0]              hit_absorbed
);

   localparam int HL_W = $clog2(HITS_MAX + 1);
   localparam int HT_W = $clog2(HOLD_FRAMES + 1);
   localparam int RT_W = $clog2(RESPAWN_FRAMES + 1);
   localparam logic [HT_W-1:0] HOLD_LOAD = HT_W'(HOLD_FRAMES - 1);
   localparam logic [RT_W-1:0] RESP_LOAD = RT_W'(RESPAWN_FRAMES - 1);
   localparam logic [9:0] GAP   = 10'(ARMOR_GAP);
   localparam logic [9:0] LONG  = 10'(ARMOR_LONG);
   localparam logic [9:0] SHORT = 10'(ARMOR_SHORT);

   upg_state_t              state, state_n;
   logic [HT_W-1:0]         hold_timer, hold_n;
   logic [RT_W-1:0]         respawn_timer, resp_n;
   logic                    vis_n;
   logic [NUM_PLAYERS-1:0]  owner_n, absorb_n;
   logic [HL_W-1:0]         hits_n;
   plate_t                  plate_q, plate_n;

   logic [NUM_PLAYERS-1:0]  overlap;
   logic [NUM_PLAYERS-1:0]  grant_oh;
   plate_t                  grant_plate, owner_plate;
   logic                    owner_hit;

   for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_hitbox
      upgrade_hitbox u_hitbox (
         .px   (PlayerX[g]),
         .py   (PlayerY[g]),
         .cx   (UpgradeX),
         .cy   (UpgradeY),
         .size (Upgrade_Size),
         .hit  (overlap[g])
      );
   end

   // Descending scan so the lowest overlapping index is the one left standing.
   always_comb begin
      grant_oh    = '0;
      grant_plate = '0;
      owner_plate = '0;
      for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
         if (overlap[i]) begin
            grant_oh    = '0;
            grant_oh[i] = 1'b1;
            grant_plate = rear_plate(PlayerX[i], PlayerY[i], Ball_Size,
                                     dir_t'(player_dir[i]), GAP, LONG, SHORT);
         end
         if (armor_owner[i]) begin
            owner_plate = rear_plate(PlayerX[i], PlayerY[i], Ball_Size,
                                     dir_t'(player_dir[i]), GAP, LONG, SHORT);
         end
      end
   end

   assign owner_hit = |(player_hit & armor_owner);

   always_comb begin
      state_n  = state;
      hold_n   = hold_timer;
      resp_n   = respawn_timer;
      vis_n    = upgrade_visible;
      owner_n  = armor_owner;
      hits_n   = hits_left;
      plate_n  = plate_q;
      absorb_n = '0;
      case (state)
         SPAWNED: begin
            if (|grant_oh) begin
               state_n = HELD;
               owner_n = grant_oh;
               hits_n  = HL_W'(HITS_MAX);
               hold_n  = HOLD_LOAD;
               vis_n   = 1'b0;
               plate_n = grant_plate;
            end
         end
         HELD: begin
            plate_n = owner_plate;
            if (hold_timer != '0) hold_n = hold_timer - 1'b1;
            if (owner_hit && hits_left != '0) begin
               absorb_n = armor_owner;
               hits_n   = hits_left - 1'b1;
            end
            // A final hit on the expiry frame still pulses before the plate is dropped.
            if ((owner_hit && hits_left == HL_W'(1)) || hold_timer == '0) begin
               state_n = RESPAWN;
               owner_n = '0;
               plate_n = '0;
               hits_n  = '0;
               hold_n  = '0;
               resp_n  = RESP_LOAD;
            end
         end
         RESPAWN: begin
            if (respawn_timer == '0) begin
               state_n = SPAWNED;
               vis_n   = 1'b1;
            end else begin
               resp_n = respawn_timer - 1'b1;
            end
         end
         default: begin
            state_n = SPAWNED;
            vis_n   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state           <= SPAWNED;
         hold_timer      <= '0;
         respawn_timer   <= '0;
         upgrade_visible <= 1'b1;
         armor_owner     <= '0;
         hits_left       <= '0;
         plate_q         <= '0;
         hit_absorbed    <= '0;
      end else begin
         state           <= state_n;
         hold_timer      <= hold_n;
         respawn_timer   <= resp_n;
         upgrade_visible <= vis_n;
         armor_owner     <= owner_n;
         hits_left       <= hits_n;
         plate_q         <= plate_n;
         hit_absorbed    <= absorb_n;
      end
   end

   assign ArmorX              = plate_q.x;
   assign ArmorY              = plate_q.y;
   assign Armor_Length_Halved = plate_q.len;
   assign Armor_Height_Halved = plate_q.ht;

endmodule

// File: tb/tb_upgrade_armor_ctrl.sv
// Scoreboard bench for upgrade_armor_ctrl: per-frame expected outputs are
// queued with each stimulus row and compared after the following edge.
module tb_upgrade_armor_ctrl;

   localparam int NP = 2;
   localparam int F  = 500;

   logic                 frame_clk = 1'b0;
   logic                 Reset;
   logic [NP-1:0][9:0]   PlayerX, PlayerY;
   logic [9:0]           Ball_Size;
   logic [NP-1:0][1:0]   player_dir;
   logic [NP-1:0]        player_hit;
   logic [9:0]           UpgradeX, UpgradeY, Upgrade_Size;
   logic                 upgrade_visible;
   logic [NP-1:0]        armor_owner;
   logic [9:0]           ArmorX, ArmorY, Armor_Length_Halved, Armor_Height_Halved;
   logic [1:0]           hits_left;
   logic [NP-1:0]        hit_absorbed;

   always #5 frame_clk = ~frame_clk;

   upgrade_armor_ctrl #(
      .NUM_PLAYERS(NP), .HOLD_FRAMES(8), .RESPAWN_FRAMES(4), .HITS_MAX(2)
   ) dut (
      .frame_clk(frame_clk), .Reset(Reset),
      .PlayerX(PlayerX), .PlayerY(PlayerY), .Ball_Size(Ball_Size),
      .player_dir(player_dir), .player_hit(player_hit),
      .UpgradeX(UpgradeX), .UpgradeY(UpgradeY), .Upgrade_Size(Upgrade_Size),
      .upgrade_visible(upgrade_visible), .armor_owner(armor_owner),
      .ArmorX(ArmorX), .ArmorY(ArmorY),
      .Armor_Length_Halved(Armor_Length_Halved), .Armor_Height_Halved(Armor_Height_Halved),
      .hits_left(hits_left), .hit_absorbed(hit_absorbed)
   );

   typedef struct packed {
      logic       vis;
      logic [1:0] own;
      logic [9:0] ax, ay, lh, hh;
      logic [1:0] hl;
      logic [1:0] ab;
   } obs_t;

   typedef struct packed {
      logic       rst;
      logic [9:0] x0, y0;
      logic [1:0] d0;
      logic [9:0] x1, y1;
      logic [1:0] d1;
      logic [1:0] hit;
   } stim_t;

   obs_t obs;
   assign obs = {upgrade_visible, armor_owner, ArmorX, ArmorY,
                 Armor_Length_Halved, Armor_Height_Halved, hits_left, hit_absorbed};

   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   function automatic obs_t ex(int vis, int own, int ax, int ay, int lh, int hh, int hl, int ab);
      obs_t o;
      o.vis = 1'(vis); o.own = 2'(own);
      o.ax = 10'(ax); o.ay = 10'(ay); o.lh = 10'(lh); o.hh = 10'(hh);
      o.hl = 2'(hl); o.ab = 2'(ab);
      return o;
   endfunction

   function automatic stim_t st(int rst, int x0, int y0, int d0, int x1, int y1, int d1, int hit);
      stim_t s;
      s.rst = 1'(rst);
      s.x0 = 10'(x0); s.y0 = 10'(y0); s.d0 = 2'(d0);
      s.x1 = 10'(x1); s.y1 = 10'(y1); s.d1 = 2'(d1);
      s.hit = 2'(hit);
      return s;
   endfunction

   task automatic apply(input stim_t s);
      Reset         = s.rst;
      PlayerX[0]    = s.x0; PlayerY[0] = s.y0; player_dir[0] = s.d0;
      PlayerX[1]    = s.x1; PlayerY[1] = s.y1; player_dir[1] = s.d1;
      player_hit    = s.hit;
   endtask

   task automatic tick();
      @(posedge frame_clk);
      #1;
   endtask

   task automatic set_upgrade(input int x, input int y, input int sz);
      UpgradeX = 10'(x); UpgradeY = 10'(y); Upgrade_Size = 10'(sz);
   endtask

   task automatic test_reset();
      stim_t sq[$];
      obs_t  eq[$];
      obs_t  want;
      sq.push_back(st(1, F, F, 0, F, F, 0, 0)); eq.push_back(ex(1, 0, 0, 0, 0, 0, 0, 0));
      sq.push_back(st(0, F, F, 0, F, F, 0, 3)); eq.push_back(ex(1, 0, 0, 0, 0, 0, 0, 0));
      foreach (sq[k]) begin
         apply(sq[k]); exp_q.push_back(eq[k]); tick();
         want = exp_q.pop_front(); n_checks++;
         if (obs !== want) begin
            n_errors++;
            $display("FAIL reset[%0d]: got %h want %h", k, obs, want);
         end
      end
   endtask

   task automatic test_pickup();
      stim_t sq[$];
      obs_t  eq[$];
      obs_t  want;
      sq.push_back(st(0, 104, 96, 1, F, F, 0, 0)); eq.push_back(ex(0, 1, 90, 96, 4, 12, 2, 0));
      sq.push_back(st(0, 104, 96, 0, F, F, 0, 0)); eq.push_back(ex(0, 1, 118, 96, 4, 12, 2, 0));
      sq.push_back(st(0, 104, 96, 3, F, F, 0, 0)); eq.push_back(ex(0, 1, 104, 110, 12, 4, 2, 0));
      sq.push_back(st(0, 104, 96, 2, F, F, 0, 0)); eq.push_back(ex(0, 1, 104, 82, 12, 4, 2, 0));
      sq.push_back(st(1, F, F, 0, F, F, 0, 0));    eq.push_back(ex(1, 0, 0, 0, 0, 0, 0, 0));
      foreach (sq[k]) begin
         apply(sq[k]); exp_q.push_back(eq[k]); tick();
         want = exp_q.pop_front(); n_checks++;
         if (obs !== want) begin
            n_errors++;
            $display("FAIL pickup[%0d]: got %h want %h", k, obs, want);
         end
      end
   endtask

   // Tie goes to P0; plate expires after 8 held frames, 4 respawn frames follow
   // with P1 overlapping throughout, then P1 takes the relocated pickup.
   task automatic test_tie_expiry();
      stim_t sq[$];
      obs_t  eq[$];
      obs_t  want;
      for (int i = 0; i < 8; i++) begin
         sq.push_back(st(0, 100, 100, 1, 100, 100, 2, 0));
         eq.push_back(ex(0, 1, 86, 100, 4, 12, 2, 0));
      end
      for (int i = 0; i < 4; i++) begin
         sq.push_back(st(0, F, F, 1, 100, 100, 2, 0));
         eq.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0));
      end
      sq.push_back(st(0, F, F, 1, 100, 100, 2, 0)); eq.push_back(ex(1, 0, 0, 0, 0, 0, 0, 0));
      foreach (sq[k]) begin
         apply(sq[k]); exp_q.push_back(eq[k]); tick();
         want = exp_q.pop_front(); n_checks++;
         if (obs !== want) begin
            n_errors++;
            $display("FAIL tie_expiry[%0d]: got %h want %h", k, obs, want);
         end
      end
      set_upgrade(50, 60, 8);
      apply(st(0, F, F, 1, 50, 60, 2, 0)); exp_q.push_back(ex(0, 2, 50, 46, 12, 4, 2, 0)); tick();
      want = exp_q.pop_front(); n_checks++;
      if (obs !== want) begin
         n_errors++;
         $display("FAIL tie_p1_pickup: got %h want %h", obs, want);
      end
      set_upgrade(100, 100, 8);
      apply(st(1, F, F, 0, F, F, 0, 0)); exp_q.push_back(ex(1, 0, 0, 0, 0, 0, 0, 0)); tick();
      want = exp_q.pop_front(); n_checks++;
      if (obs !== want) begin
         n_errors++;
         $display("FAIL tie_reset: got %h want %h", obs, want);
      end
   endtask

   task automatic test_hits();
      stim_t sq[$];
      obs_t  eq[$];
      obs_t  want;
      sq.push_back(st(0, 100, 100, 1, F, F, 0, 0)); eq.push_back(ex(0, 1, 86, 100, 4, 12, 2, 0));
      sq.push_back(st(0, 100, 100, 1, F, F, 0, 2)); eq.push_back(ex(0, 1, 86, 100, 4, 12, 2, 0));
      sq.push_back(st(0, 100, 100, 1, F, F, 0, 1)); eq.push_back(ex(0, 1, 86, 100, 4, 12, 1, 1));
      sq.push_back(st(0, 100, 100, 1, F, F, 0, 0)); eq.push_back(ex(0, 1, 86, 100, 4, 12, 1, 0));
      sq.push_back(st(0, 100, 100, 1, F, F, 0, 1)); eq.push_back(ex(0, 0, 0, 0, 0, 0, 0, 1));
      sq.push_back(st(0, 100, 100, 1, F, F, 0, 1)); eq.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0));
      sq.push_back(st(1, F, F, 0, F, F, 0, 0));     eq.push_back(ex(1, 0, 0, 0, 0, 0, 0, 0));
      foreach (sq[k]) begin
         apply(sq[k]); exp_q.push_back(eq[k]); tick();
         want = exp_q.pop_front(); n_checks++;
         if (obs !== want) begin
            n_errors++;
            $display("FAIL hits[%0d]: got %h want %h", k, obs, want);
         end
      end
   endtask

   // Second hit lands on the same edge the hold timer reaches zero.
   task automatic test_simultaneous();
      stim_t sq[$];
      obs_t  eq[$];
      obs_t  want;
      sq.push_back(st(0, 100, 100, 1, F, F, 0, 0)); eq.push_back(ex(0, 1, 86, 100, 4, 12, 2, 0));
      for (int i = 0; i < 2; i++) begin
         sq.push_back(st(0, 100, 100, 1, F, F, 0, 0)); eq.push_back(ex(0, 1, 86, 100, 4, 12, 2, 0));
      end
      sq.push_back(st(0, 100, 100, 1, F, F, 0, 1)); eq.push_back(ex(0, 1, 86, 100, 4, 12, 1, 1));
      for (int i = 0; i < 4; i++) begin
         sq.push_back(st(0, 100, 100, 1, F, F, 0, 0)); eq.push_back(ex(0, 1, 86, 100, 4, 12, 1, 0));
      end
      sq.push_back(st(0, 100, 100, 1, F, F, 0, 1)); eq.push_back(ex(0, 0, 0, 0, 0, 0, 0, 1));
      sq.push_back(st(0, F, F, 1, F, F, 0, 0));     eq.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0));
      sq.push_back(st(1, F, F, 0, F, F, 0, 0));     eq.push_back(ex(1, 0, 0, 0, 0, 0, 0, 0));
      foreach (sq[k]) begin
         apply(sq[k]); exp_q.push_back(eq[k]); tick();
         want = exp_q.pop_front(); n_checks++;
         if (obs !== want) begin
            n_errors++;
            $display("FAIL simultaneous[%0d]: got %h want %h", k, obs, want);
         end
      end
   endtask

   task automatic test_edge_reset();
      obs_t want;
      set_upgrade(4, 4, 8);
      apply(st(0, 0, 0, 0, F, F, 0, 0)); exp_q.push_back(ex(0, 1, 14, 0, 4, 12, 2, 0)); tick();
      apply(st(0, 0, 0, 0, F, F, 0, 0)); exp_q.push_back(ex(0, 1, 14, 0, 4, 12, 2, 0)); tick();
      want = exp_q.pop_front(); n_checks++;
      if (obs !== want && obs !== exp_q[0]) begin
         n_errors++;
         $display("FAIL edge_low_sat: got %h want %h", obs, want);
      end
      want = exp_q.pop_front(); n_checks++;
      if (obs !== want) begin
         n_errors++;
         $display("FAIL edge_low_held: got %h want %h", obs, want);
      end
      apply(st(1, 0, 0, 0, F, F, 0, 1)); exp_q.push_back(ex(1, 0, 0, 0, 0, 0, 0, 0)); tick();
      want = exp_q.pop_front(); n_checks++;
      if (obs !== want) begin
         n_errors++;
         $display("FAIL edge_reset_mid_held: got %h want %h", obs, want);
      end
      set_upgrade(1020, 1020, 8);
      apply(st(0, 1023, 1023, 0, F, F, 0, 0)); exp_q.push_back(ex(0, 1, 13, 1023, 4, 12, 2, 0)); tick();
      want = exp_q.pop_front(); n_checks++;
      if (obs !== want) begin
         n_errors++;
         $display("FAIL edge_high_sat: got %h want %h", obs, want);
      end
      apply(st(1, F, F, 0, F, F, 0, 0)); exp_q.push_back(ex(1, 0, 0, 0, 0, 0, 0, 0)); tick();
      want = exp_q.pop_front(); n_checks++;
      if (obs !== want) begin
         n_errors++;
         $display("FAIL edge_final_reset: got %h want %h", obs, want);
      end
      set_upgrade(100, 100, 8);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      Ball_Size = 10'd4;
      set_upgrade(100, 100, 8);
      apply(st(1, F, F, 0, F, F, 0, 0));
      tick();
      test_reset();
      test_pickup();
      test_tie_expiry();
      test_hits();
      test_simultaneous();
      test_edge_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/upgrade_armor_ctrl.md
Name: upgrade_armor_ctrl

Overview:
- Parametrised armor power-up controller for NUM_PLAYERS tanks.
- Owns one pickup through a spawn → held → respawn lifecycle and arbitrates which player collects it.
- While held, it places the armor plate at the owner's rear, absorbs up to HITS_MAX hits and expires after HOLD_FRAMES frames.
- Sits between the player motion blocks, the hit/collision logic and the sprite/colour mapper; all timing is per frame_clk tick.

Parameters:
- NUM_PLAYERS, 2, number of players checked for pickup (1..8).
- ARMOR_LONG, 12, half-extent of the plate along its long side (pixels).
- ARMOR_SHORT, 4, half-extent of the plate along its short side (pixels).
- ARMOR_GAP, 10, distance from the player edge to the plate centre.
- HOLD_FRAMES, 600, frames the armor lasts once collected.
- RESPAWN_FRAMES, 300, frames between armor loss and the pickup reappearing.
- HITS_MAX, 3, hits absorbed before the armor breaks.

Ports:
- frame_clk  in  1  frame clock; sole clock.
- Reset  in  1  synchronous, active-high reset, sampled on posedge frame_clk.
- PlayerX  in  [NUM_PLAYERS-1:0][9:0]  player centre X.
- PlayerY  in  [NUM_PLAYERS-1:0][9:0]  player centre Y.
- Ball_Size  in  10  player half-size.
- player_dir  in  [NUM_PLAYERS-1:0][1:0]  facing: 00 left, 01 right, 10 down, 11 up.
- player_hit  in  [NUM_PLAYERS-1:0]  one-frame pulse: player struck this frame.
- UpgradeX, UpgradeY, Upgrade_Size  in  10 each  pickup centre and half-size.
- upgrade_visible  out  1  pickup is on the field (state SPAWNED).
- armor_owner  out  NUM_PLAYERS  one-hot holder; all zeros when not held.
- ArmorX, ArmorY  out  10 each  plate centre.
- Armor_Length_Halved, Armor_Height_Halved  out  10 each  plate half-extents in X and Y.
- hits_left  out  $clog2(HITS_MAX+1)  remaining absorbable hits.
- hit_absorbed  out  NUM_PLAYERS  one-frame pulse per absorbed hit, one-hot to the owner.

Behaviour:
- Reset values: state=SPAWNED, upgrade_visible=1, armor_owner=0, ArmorX/Y=0, halves=0, hits_left=0, hit_absorbed=0, both timers=0.
- All outputs are registered.
- Overlap test for player i: PlayerX in [UpgradeX-Upgrade_Size, UpgradeX+Upgrade_Size] and PlayerY in the same span on Y, bounds inclusive.
  - Bounds are computed in 11 bits; the low bound saturates at 0 and the high bound at 1023.
- SPAWNED:
  - If any player overlaps, the lowest index wins.
  - Next edge: state=HELD, armor_owner=onehot(i), hits_left=HITS_MAX, hold_timer=HOLD_FRAMES-1, upgrade_visible=0.
  - The plate position for player i is latched on that same edge, so it is valid in the first HELD frame.
- HELD, every edge: plate position and halves are recomputed from the owner's current X/Y/dir. The plate always sits at the owner's rear:
  - dir 00: X=PX+Ball_Size+ARMOR_GAP, Y=PY, Length=ARMOR_SHORT, Height=ARMOR_LONG.
  - dir 01: X=PX-Ball_Size-ARMOR_GAP, Y=PY, Length=ARMOR_SHORT, Height=ARMOR_LONG.
  - dir 10: X=PX, Y=PY-Ball_Size-ARMOR_GAP, Length=ARMOR_LONG, Height=ARMOR_SHORT.
  - dir 11: X=PX, Y=PY+Ball_Size+ARMOR_GAP, Length=ARMOR_LONG, Height=ARMOR_SHORT.
  - Position arithmetic truncates to 10 bits (mod 1024); the renderer clips.
- HELD, hits and expiry:
  - player_hit[owner]=1: hit_absorbed[owner]=1 for one frame and hits_left decrements.
  - player_hit on any non-owner is ignored and gives no pulse.
  - hold_timer decrements every frame.
  - Exit to RESPAWN when a hit arrives with hits_left==1, or when hold_timer==0, whichever comes first.
  - If both happen on the same edge, the hit is still absorbed (pulse asserted, hits_left→0) and the state goes to RESPAWN.
- RESPAWN, on entry: armor_owner=0, ArmorX/Y and halves=0, hits_left=0, respawn_timer=RESPAWN_FRAMES-1.
  - The timer decrements each frame; at 0 the next edge goes to SPAWNED and sets upgrade_visible=1.
  - Overlaps are ignored during RESPAWN.
- Reset in any state, including mid-HELD or mid-RESPAWN, returns all registers to reset values on that edge; there is no pending pulse.
- Counters never wrap; each saturates at 0 because it only decrements while its own state is active.

Decomposition:
- Shared package upgrade_pkg:
  - dir_t enum: DIR_LEFT=00, DIR_RIGHT=01, DIR_DOWN=10, DIR_UP=11.
  - upg_state_t enum: SPAWNED, HELD, RESPAWN.
  - Default constants for gap and armor dimensions, shared with the other upgrade blocks.
- Sub-module upgrade_hitbox: combinational saturating box-overlap check, instantiated NUM_PLAYERS times.
  - Reused by the future speed/ammo upgrade controllers.

Test Plan:
Bench overrides: HOLD_FRAMES=8, RESPAWN_FRAMES=4, HITS_MAX=2, NUM_PLAYERS=2, Ball_Size=4, Upgrade at (100,100), size 8.
- Pickup: P0=(104,96) dir 01 → next edge owner=01, ArmorX=90, ArmorY=96, Length_Halved=4, Height_Halved=12, hits_left=2, upgrade_visible=0.
- Tie: P0 and P1 both at (100,100) on the same frame → owner=01 only. Then with P1 alone, dir 10, at (50,60) after P0's armor expires and respawns → owner=10, ArmorX=50, ArmorY=46, Length=12, Height=4.
- Hits: owner P0, pulse player_hit=01 twice on separate frames → hit_absorbed=01 both times, hits_left 2→1→0, RESPAWN after second; player_hit=10 gives no pulse.
- Expiry: no hits after pickup → exactly 8 HELD frames, then owner=0, 4 RESPAWN frames, then upgrade_visible=1; a player overlapping during RESPAWN is not granted.
- Simultaneous: last hit on the same edge as hold_timer==0 → one hit_absorbed pulse, single transition to RESPAWN.
- Edge/reset: Upgrade at (4,4) size 8, P0=(0,0) → collected (low bound saturates). Reset asserted mid-HELD → all outputs at reset values on the next edge, upgrade_visible=1.
